// File: rtl/binary_logic_pkg.sv
// Shared constants and helpers for the BinaryLogic group of ALU helper blocks.
//   clog2()       : ceiling log2 of a positive integer (clog2(1) = 0)
//   DIR_LEFT/RIGHT: direction selectors for shift_stage
//   SHAMT_STAGES  : barrel stage count for the default 4-bit datapath
package binary_logic_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  localparam int unsigned DIR_LEFT  = 0;
  localparam int unsigned DIR_RIGHT = 1;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned SHAMT_STAGES  = clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/shift_stage.sv
// One mux stage of a logical barrel shifter.
//   en   : when high, shift din by DIST bits in direction DIR; otherwise pass through
//   din  : stage input
//   dout : stage output, vacated bits zero-filled
module shift_stage
  import binary_logic_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIST  = 1,
  parameter int unsigned DIR   = DIR_LEFT
) (
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = '0;
    if (DIR == DIR_LEFT) begin
      shifted = din << DIST;
    end else begin
      shifted = din >> DIST;
    end
  end

  assign dout = en ? shifted : din;

endmodule

// File: rtl/shifter.sv
// Registered logical barrel shifter; left and right results produced in parallel.
//   clk                : system clock, rising edge
//   rst                : synchronous active-high reset
//   in_valid           : qualifies a/b this cycle
//   a                  : operand
//   b                  : unsigned shift amount, all bits significant
//   out_valid          : results hold the shift of a valid input (one-cycle pulse per input)
//   left_shift_result  : a << b, zero fill
//   right_shift_result : a >> b, zero fill
module shifter
  import binary_logic_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] left_shift_result,
  output logic [WIDTH-1:0] right_shift_result
);

  localparam int unsigned STAGES = clog2(WIDTH);

  // Index 0 is the raw operand; index STAGES is the fully shifted value.
  logic [WIDTH-1:0] left_chain  [STAGES+1];
  logic [WIDTH-1:0] right_chain [STAGES+1];
  logic             overflow;
  logic [WIDTH-1:0] left_d;
  logic [WIDTH-1:0] right_d;

  assign left_chain[0]  = a;
  assign right_chain[0] = a;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    shift_stage #(
      .WIDTH(WIDTH),
      .DIST (2 ** k),
      .DIR  (DIR_LEFT)
    ) u_left (
      .en  (b[k]),
      .din (left_chain[k]),
      .dout(left_chain[k+1])
    );

    shift_stage #(
      .WIDTH(WIDTH),
      .DIST (2 ** k),
      .DIR  (DIR_RIGHT)
    ) u_right (
      .en  (b[k]),
      .din (right_chain[k]),
      .dout(right_chain[k+1])
    );
  end

  // Shift amounts with any bit at or above STAGES exceed WIDTH-1 and clear everything.
  // Amounts in [WIDTH, 2**STAGES) already shift every bit out inside the barrel.
  if (STAGES < WIDTH) begin : g_ovf
    assign overflow = |b[WIDTH-1:STAGES];
  end else begin : g_no_ovf
    assign overflow = 1'b0;
  end

  assign left_d  = overflow ? '0 : left_chain[STAGES];
  assign right_d = overflow ? '0 : right_chain[STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      left_shift_result  <= '0;
      right_shift_result <= '0;
      out_valid          <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Results hold on idle cycles.
      if (in_valid) begin
        left_shift_result  <= left_d;
        right_shift_result <= right_d;
      end
    end
  end

endmodule

// File: tb/tb_shifter.sv
module tb_shifter;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned MASK  = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] left_shift_result;
  logic [WIDTH-1:0] right_shift_result;

  int checks;
  int errors;

  // Reference state, updated once per clock edge from the rules of the block.
  int exp_left;
  int exp_right;
  int exp_valid;

  shifter #(
    .WIDTH(WIDTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .a                 (a),
    .b                 (b),
    .out_valid         (out_valid),
    .left_shift_result (left_shift_result),
    .right_shift_result(right_shift_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int ref_left(input int op, input int amt);
    if (amt >= WIDTH) return 0;
    return (op * (1 << amt)) & MASK;
  endfunction

  function automatic int ref_right(input int op, input int amt);
    if (amt >= WIDTH) return 0;
    return op / (1 << amt);
  endfunction

  // Apply one cycle of stimulus, advance the model, then compare #1 after the edge.
  task automatic step(input string tag, input logic r, input logic v,
                      input int op, input int amt);
    rst      = r;
    in_valid = v;
    a        = op[WIDTH-1:0];
    b        = amt[WIDTH-1:0];
    @(posedge clk);
    if (r) begin
      exp_left  = 0;
      exp_right = 0;
      exp_valid = 0;
    end else begin
      exp_valid = v ? 1 : 0;
      if (v) begin
        exp_left  = ref_left(op, amt);
        exp_right = ref_right(op, amt);
      end
    end
    #1;
    check({tag, ".valid"}, int'(out_valid), exp_valid);
    check({tag, ".left"}, int'(left_shift_result), exp_left);
    check({tag, ".right"}, int'(right_shift_result), exp_right);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_left  = 0;
    exp_right = 0;
    exp_valid = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;

    step("reset", 1'b1, 1'b0, 0, 0);
    step("reset2", 1'b1, 1'b1, 'hF, 0);

    // Directed cases from the test plan, with constant expectations as a cross-check.
    step("d_1101_2", 1'b0, 1'b1, 'b1101, 2);
    check("d_1101_2.left_const", int'(left_shift_result), 'b0100);
    check("d_1101_2.right_const", int'(right_shift_result), 'b0011);
    step("d_1001_1", 1'b0, 1'b1, 'b1001, 1);
    check("d_1001_1.left_const", int'(left_shift_result), 'b0010);
    check("d_1001_1.right_const", int'(right_shift_result), 'b0100);
    step("d_b0", 1'b0, 1'b1, 'b1011, 0);
    check("d_b0.left_const", int'(left_shift_result), 'b1011);
    step("d_b4", 1'b0, 1'b1, 'b1111, 4);
    check("d_b4.right_const", int'(right_shift_result), 0);
    step("d_b15", 1'b0, 1'b1, 'b1111, 15);
    step("d_b3", 1'b0, 1'b1, 'b1111, 3);
    step("d_b8", 1'b0, 1'b1, 'b1111, 8);
    step("btb1", 1'b0, 1'b1, 'b0110, 1);
    check("btb1.left_const", int'(left_shift_result), 'b1100);
    step("btb2", 1'b0, 1'b1, 'b0110, 3);
    step("idle", 1'b0, 1'b0, 'b1010, 1);
    check("idle.hold_const", int'(left_shift_result), 0);
    step("idle2", 1'b0, 1'b0, 'b0101, 0);
    step("load", 1'b0, 1'b1, 'b1010, 1);
    step("rst_over_valid", 1'b1, 1'b1, 'b1101, 1);
    check("rst_over_valid.left_const", int'(left_shift_result), 0);
    step("post_rst", 1'b0, 1'b1, 'b0011, 1);
    check("post_rst.left_const", int'(left_shift_result), 'b0110);
    check("post_rst.right_const", int'(right_shift_result), 'b0001);

    // Exhaustive operand/amount sweep, back-to-back.
    for (int op = 0; op < 16; op++) begin
      for (int amt = 0; amt < 16; amt++) begin
        step("sweep", 1'b0, 1'b1, op, amt);
      end
    end

    // Random traffic with idle gaps and occasional mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic v;
      r = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 3) != 0);
      step("rand", r, v, int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shifter.md
Name: shifter

Overview:
- Registered logical barrel shifter.
- Takes an operand `a` and a shift amount `b`, and produces both a left-shifted and a right-shifted result in parallel.
- Part of the BinaryLogic group of ALU helper blocks; feeds the ALU result mux.
- Outputs are registered, with one clock of latency from input to output.

Parameters:
- WIDTH, 4, bit width of operand `a`, shift amount `b`, and both results.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies `a`/`b` in the current cycle.
- a  input  WIDTH  operand to shift.
- b  input  WIDTH  shift amount, unsigned; all WIDTH bits are significant.
- out_valid  output  1  high for one cycle when the results hold the shift of a valid input.
- left_shift_result  output  WIDTH  `a << b`, logical, zero fill from the LSB side.
- right_shift_result  output  WIDTH  `a >> b`, logical, zero fill from the MSB side.

Behaviour:
- Reset:
  - Reset is sampled at the rising edge of `clk`.
  - While `rst`=1 at an edge: `left_shift_result`=0, `right_shift_result`=0, `out_valid`=0.
  - Reset overrides any simultaneous `in_valid`.
  - Reset asserted mid-stream discards the in-flight result; the first valid output after release is from the first input accepted after release.
- Latency:
  - If `in_valid`=1 at edge N (no reset), then after edge N the results equal the shifts of the `a`/`b` sampled at edge N, and `out_valid`=1.
  - If `in_valid`=0 at an edge: `out_valid`=0, and both result registers hold their previous values (no toggling on idle).
- Throughput: one new operation per cycle. There is no backpressure and no ready signal.
- Arithmetic:
  - Logical shifts only; no sign extension.
  - Vacated bits are 0; bits shifted past either end are discarded.
- Boundary conditions:
  - `b`=0: both results equal `a`.
  - `b` >= WIDTH, including all values up to 2^WIDTH-1: both results are 0.
  - This must hold for any WIDTH, including non-power-of-2 widths where `b` exceeds WIDTH-1.
- Structure:
  - Combinational core is a log2 barrel: stage k shifts by 2^k when `b[k]`=1.
  - Any set bit of `b` at or above position ceil(log2(WIDTH)) forces a zero result.
  - Left and right paths are independent but share the same `b` decode.
- No X propagation from the result registers after reset.

Decomposition:
- Shared package `binary_logic_pkg`:
  - Constant `SHAMT_STAGES` = ceil(log2(WIDTH)), via a `clog2` function.
  - No typedefs are needed beyond logic vectors.
- One natural sub-module: `shift_stage`.
  - Parameters: WIDTH, DIST, DIR.
  - Function: a single mux stage shifting by DIST in direction DIR when its enable is set.
  - Instantiated SHAMT_STAGES times per direction.
- Top level holds:
  - the overflow detect on the upper bits of `b`;
  - the output registers;
  - the `out_valid` register.

Test Plan:
- `a`=1101, `b`=0010, `in_valid`=1 -> next cycle: `left_shift_result`=0100, `right_shift_result`=0011, `out_valid`=1.
- `a`=1001, `b`=0001, `in_valid`=1 -> next cycle: left=0010, right=0100, `out_valid`=1.
- `a`=1011, `b`=0000 -> left=1011, right=1011.
- `a`=1111 with `b`=0100 and then `b`=1111 -> left=0000, right=0000 for both.
- Back-to-back inputs:
  - Inputs: (0110, `b`=1), then (0110, `b`=3), then `in_valid`=0.
  - Outputs: (1100, 0011) then (0000, 0000), with `out_valid`=1,1,0.
  - Results hold (0000, 0000) on the idle cycle.
- Reset with `in_valid`=1 and `a`=1101, `b`=0001 in the same cycle -> after that edge both results 0000 and `out_valid`=0.
  - Next valid input (0011, `b`=1) -> left=0110, right=0001.
